switch_allocator: RTL

- Separable input-first switch allocator for one router.
- Stage 1: each input port picks one of its VCs whose switch request is eligible.
- Stage 2: each output port picks one input among the stage-1 winners that target it.
- Grants drive the input ports' valid_sel_i/vc_sel_i (buffer read) and the crossbar select. Round-robin pointers give fairness; eligibility is gated by the downstream on/off flow control.

---
 rtl/switch_allocator_if.sv | 27 ++
 rtl/switch_allocator.sv | 104 ++++++++++
 2 files changed

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input-port buffers and the switch allocator.
// The allocator side uses the slave modport; the router datapath uses master.
interface switch_allocator_if #(
   parameter int PORT_NUM  = 5,
   parameter int VC_NUM    = 2,
   parameter int VC_SIZE   = $clog2(VC_NUM),
   parameter int PORT_SIZE = $clog2(PORT_NUM)
);
   logic [PORT_NUM-1:0][VC_NUM-1:0]                switch_request_i;
   logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i;
   logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i;
   logic [PORT_NUM-1:0][VC_NUM-1:0]                on_off_i;
   logic [PORT_NUM-1:0]                            valid_sel_o;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_sel_o;
   logic [PORT_NUM-1:0]                            xb_valid_o;

   modport master (
      output switch_request_i, out_port_i, downstream_vc_i, on_off_i,
      input  valid_sel_o, vc_sel_o, xb_sel_o, xb_valid_o
   );

   modport slave (
      input  switch_request_i, out_port_i, downstream_vc_i, on_off_i,
      output valid_sel_o, vc_sel_o, xb_sel_o, xb_valid_o
   );
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then
// per-output input round-robin. Grants are combinational; only pointers are stored.
module switch_allocator #(
   parameter int PORT_NUM  = 5,
   parameter int VC_NUM    = 2,
   parameter int VC_SIZE   = $clog2(VC_NUM),
   parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   switch_allocator_if.slave sa
);

   logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr;

   logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
   logic [PORT_NUM-1:0]                cand_valid;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;

   logic [PORT_NUM-1:0]                grant_in;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   grant_vc;
   logic [PORT_NUM-1:0]                grant_out;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] grant_sel;

   // Wrap helpers take an index in [0, 2*N) and fold it back into [0, N)
   function automatic logic [VC_SIZE-1:0] vc_wrap(input int idx);
      return (idx >= VC_NUM) ? VC_SIZE'(idx - VC_NUM) : VC_SIZE'(idx);
   endfunction

   function automatic logic [PORT_SIZE-1:0] port_wrap(input int idx);
      return (idx >= PORT_NUM) ? PORT_SIZE'(idx - PORT_NUM) : PORT_SIZE'(idx);
   endfunction

   // Eligibility: request plus downstream on/off credit; unroutable ports never qualify
   always_comb begin
      elig = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (int'(sa.out_port_i[p][v]) < PORT_NUM) begin
               elig[p][v] = sa.switch_request_i[p][v] &
                            sa.on_off_i[sa.out_port_i[p][v]][sa.downstream_vc_i[p][v]];
            end
         end
      end
   end

   // Stage 1: each input nominates one VC, searching upward from in_ptr
   always_comb begin
      cand_valid = '0;
      cand_vc    = '0;
      cand_port  = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int k = 0; k < VC_NUM; k++) begin
            if (!cand_valid[p] && elig[p][vc_wrap(int'(in_ptr[p]) + k)]) begin
               cand_valid[p] = 1'b1;
               cand_vc[p]    = vc_wrap(int'(in_ptr[p]) + k);
               cand_port[p]  = sa.out_port_i[p][vc_wrap(int'(in_ptr[p]) + k)];
            end
         end
      end
   end

   // Stage 2: each output picks one nominating input, searching upward from out_ptr
   always_comb begin
      grant_in  = '0;
      grant_vc  = '0;
      grant_out = '0;
      grant_sel = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int k = 0; k < PORT_NUM; k++) begin
            if (!grant_out[o] && cand_valid[port_wrap(int'(out_ptr[o]) + k)] &&
                cand_port[port_wrap(int'(out_ptr[o]) + k)] == PORT_SIZE'(o)) begin
               grant_out[o] = 1'b1;
               grant_sel[o] = port_wrap(int'(out_ptr[o]) + k);
               grant_in[port_wrap(int'(out_ptr[o]) + k)] = 1'b1;
               grant_vc[port_wrap(int'(out_ptr[o]) + k)] =
                  cand_vc[port_wrap(int'(out_ptr[o]) + k)];
            end
         end
      end
   end

   // Reset blanks every grant so no buffer is read while the router is held
   assign sa.valid_sel_o = rst ? grant_in  : '0;
   assign sa.vc_sel_o    = rst ? grant_vc  : '0;
   assign sa.xb_valid_o  = rst ? grant_out : '0;
   assign sa.xb_sel_o    = rst ? grant_sel : '0;

   // Input pointers move only on a final grant, so a stage-2 loser keeps its priority
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_ptr  <= '0;
         out_ptr <= '0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            if (grant_in[p])  in_ptr[p]  <= vc_wrap(int'(grant_vc[p]) + 1);
            if (grant_out[p]) out_ptr[p] <= port_wrap(int'(grant_sel[p]) + 1);
         end
      end
   end

endmodule
